// File: rtl/screen_arbiter_pkg.sv
// Shared definitions for the screen RAM arbiter: RAM owner encoding and
// the screen window of the memory map.
package screen_arbiter_pkg;

  localparam int unsigned SCREEN_BASE  = 16384;
  localparam int unsigned SCREEN_WORDS = 8192;

  // Width of the consecutive-VGA-grant counter (MAX_WAIT range 1-15).
  localparam int unsigned WAIT_W = 4;

  // Owner of the single RAM port in a given cycle.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    VGA    = 2'd1,
    CPU_RD = 2'd2,
    CPU_WR = 2'd3
  } owner_e;

endpackage

// File: rtl/screen_wbuf.sv
// One-entry CPU write buffer for the screen arbiter.
// Ports:
//   clk, reset          - clock, async active-high reset (empties the entry)
//   wr_i                - capture wr_addr_i/wr_data_i (wins over drain_i)
//   drain_i             - entry is written to RAM this cycle
//   rd_addr_i           - CPU read address compared against the entry
//   full_o/addr_o/data_o- registered entry state
//   match_c_o           - combinational: entry valid and address equal
module screen_wbuf
  import screen_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W = 13,
  parameter int unsigned DATA_W = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_i,
  input  logic              drain_i,
  input  logic [ADDR_W-1:0] wr_addr_i,
  input  logic [DATA_W-1:0] wr_data_i,
  input  logic [ADDR_W-1:0] rd_addr_i,
  output logic              full_o,
  output logic [ADDR_W-1:0] addr_o,
  output logic [DATA_W-1:0] data_o,
  output logic              match_c_o
);

  logic              full_q, full_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] data_q, data_d;

  // A capture in the drain cycle refills the entry immediately.
  always_comb begin
    full_d = full_q;
    addr_d = addr_q;
    data_d = data_q;
    if (drain_i) full_d = 1'b0;
    if (wr_i) begin
      full_d = 1'b1;
      addr_d = wr_addr_i;
      data_d = wr_data_i;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      full_q <= 1'b0;
      addr_q <= '0;
      data_q <= '0;
    end else begin
      full_q <= full_d;
      addr_q <= addr_d;
      data_q <= data_d;
    end
  end

  assign full_o    = full_q;
  assign addr_o    = addr_q;
  assign data_o    = data_q;
  assign match_c_o = full_q && (addr_q == rd_addr_i);

endmodule

// File: rtl/screen_arbiter.sv
// Screen RAM arbiter: shares one single-port screen RAM between the VGA
// fetch engine and the CPU, one access per cycle. VGA has priority unless
// a CPU op has waited MAX_WAIT VGA grants. CPU writes go through a
// one-entry buffer. Optional macro SCREEN_ARB_FWD_EN forwards buffered
// write data to a matching CPU read without touching the RAM.
// Ports:
//   clk, reset                     - clock, async active-high reset
//   cpuAddr/cpuLoad/cpuRead/cpuIn  - CPU request side
//   cpuOut/cpuRdValid/cpuStall     - CPU response and backpressure
//   vgaReq/vgaAddr                 - VGA fetch request
//   vgaData/vgaValid               - VGA fetch response
//   ramAddr/ramWe/ramDin/ramDout   - screen RAM, 1-cycle read latency
module screen_arbiter
  import screen_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W   = 13,
  parameter int unsigned DATA_W   = 16,
  parameter int unsigned MAX_WAIT = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] cpuAddr,
  input  logic              cpuLoad,
  input  logic              cpuRead,
  input  logic [DATA_W-1:0] cpuIn,
  output logic [DATA_W-1:0] cpuOut,
  output logic              cpuRdValid,
  output logic              cpuStall,
  input  logic              vgaReq,
  input  logic [ADDR_W-1:0] vgaAddr,
  output logic [DATA_W-1:0] vgaData,
  output logic              vgaValid,
  output logic [ADDR_W-1:0] ramAddr,
  output logic              ramWe,
  output logic [DATA_W-1:0] ramDin,
  input  logic [DATA_W-1:0] ramDout
);

`ifdef SCREEN_ARB_FWD_EN
  localparam bit FWD_EN = 1'b1;
`else
  localparam bit FWD_EN = 1'b0;
`endif

  owner_e            state_q, state_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic              ld_done_q, ld_done_d;
  logic              fwd_q, fwd_d;
  logic [DATA_W-1:0] fwd_data_q, fwd_data_d;

  logic              buf_full, buf_match;
  logic [ADDR_W-1:0] buf_addr;
  logic [DATA_W-1:0] buf_data;

  logic rd_valid_c, rd_req, ld_eff, fwd_hit, rd_elig, cpu_pend;
  logic drain, wr_stall, wr_accept;

  screen_wbuf #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_wbuf (
    .clk       (clk),
    .reset     (reset),
    .wr_i      (wr_accept),
    .drain_i   (drain),
    .wr_addr_i (cpuAddr),
    .wr_data_i (cpuIn),
    .rd_addr_i (cpuAddr),
    .full_o    (buf_full),
    .addr_o    (buf_addr),
    .data_o    (buf_data),
    .match_c_o (buf_match)
  );

  // Arbitration, buffer control and output routing.
  always_comb begin
    state_d    = IDLE;
    wait_d     = wait_q;
    ld_done_d  = 1'b0;
    fwd_d      = 1'b0;
    fwd_data_d = '0;
    ramAddr    = '0;
    ramWe      = 1'b0;
    ramDin     = '0;

    // cpuRead stays high through its valid cycle; do not reissue it then.
    rd_valid_c = (state_q == CPU_RD) || fwd_q;
    rd_req     = cpuRead && !rd_valid_c;
    // A held cpuLoad that was already captured under a read stall is stale.
    ld_eff     = cpuLoad && !ld_done_q;
    fwd_hit    = FWD_EN && rd_req && buf_match;
    // Reads wait behind a buffered or same-cycle write to keep ordering.
    rd_elig    = rd_req && !fwd_hit && !ld_eff && !buf_full;
    cpu_pend   = buf_full || rd_elig;

    if (!reset) begin
      if (cpu_pend && (!vgaReq || wait_q == WAIT_W'(MAX_WAIT)))
        state_d = buf_full ? CPU_WR : CPU_RD;
      else if (vgaReq)
        state_d = VGA;
    end

    drain     = (state_d == CPU_WR);
    wr_stall  = ld_eff && buf_full && !drain;
    wr_accept = ld_eff && !wr_stall;
    cpuStall  = !reset && (cpuRead || wr_stall);

    if (cpuStall && !rd_valid_c)
      ld_done_d = ld_done_q || wr_accept;

    if (state_d == CPU_RD || state_d == CPU_WR || !cpu_pend)
      wait_d = '0;
    else if (state_d == VGA && wait_q != WAIT_W'(MAX_WAIT))
      wait_d = wait_q + WAIT_W'(1);

    if (fwd_hit) begin
      fwd_d      = 1'b1;
      fwd_data_d = buf_data;
    end

    unique case (state_d)
      VGA:     ramAddr = vgaAddr;
      CPU_RD:  ramAddr = cpuAddr;
      CPU_WR: begin
        ramAddr = buf_addr;
        ramWe   = 1'b1;
        ramDin  = buf_data;
      end
      default: ramAddr = '0;
    endcase

    // Read data is steered by last cycle's owner.
    vgaValid   = (state_q == VGA);
    vgaData    = vgaValid ? ramDout : '0;
    cpuRdValid = rd_valid_c;
    cpuOut     = fwd_q ? fwd_data_q : ((state_q == CPU_RD) ? ramDout : '0);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      wait_q     <= '0;
      ld_done_q  <= 1'b0;
      fwd_q      <= 1'b0;
      fwd_data_q <= '0;
    end else begin
      state_q    <= state_d;
      wait_q     <= wait_d;
      ld_done_q  <= ld_done_d;
      fwd_q      <= fwd_d;
      fwd_data_q <= fwd_data_d;
    end
  end

endmodule

// File: tb/tb_screen_arbiter.sv
// Bench for screen_arbiter: cycle vectors with expected RAM port/handshake
// values, plus queues of expected read data checked on each valid pulse.
module tb_screen_arbiter;
  import screen_arbiter_pkg::*;

  localparam int unsigned AW = 13;
  localparam int unsigned DW = 16;

  logic          clk = 1'b0;
  logic          reset;
  logic [AW-1:0] cpuAddr, vgaAddr, ramAddr;
  logic          cpuLoad, cpuRead, cpuRdValid, cpuStall;
  logic          vgaReq, vgaValid, ramWe;
  logic [DW-1:0] cpuIn, cpuOut, vgaData, ramDin, ramDout;

  screen_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_WAIT(4)) dut (
    .clk(clk), .reset(reset),
    .cpuAddr(cpuAddr), .cpuLoad(cpuLoad), .cpuRead(cpuRead), .cpuIn(cpuIn),
    .cpuOut(cpuOut), .cpuRdValid(cpuRdValid), .cpuStall(cpuStall),
    .vgaReq(vgaReq), .vgaAddr(vgaAddr), .vgaData(vgaData), .vgaValid(vgaValid),
    .ramAddr(ramAddr), .ramWe(ramWe), .ramDin(ramDin), .ramDout(ramDout)
  );

  always #5 clk = ~clk;

  function automatic logic [DW-1:0] init_val(input int a);
    return DW'(a * 7 + 'h1357);
  endfunction

  // Synchronous-read screen RAM model, filled on the first clock.
  logic [DW-1:0] mem [SCREEN_WORDS];
  logic          ram_ready = 1'b0;
  always @(posedge clk) begin
    if (!ram_ready) begin
      for (int k = 0; k < int'(SCREEN_WORDS); k++) mem[k] <= init_val(k);
      ram_ready <= 1'b1;
    end else begin
      if (ramWe) mem[ramAddr] <= ramDin;
      ramDout <= mem[ramAddr];
    end
  end

  typedef struct {
    logic rs; logic vr; logic [AW-1:0] va;
    logic ld; logic rd; logic [AW-1:0] ca; logic [DW-1:0] cd;
    logic pv; logic pc; logic wn;
    logic e_we; logic [AW-1:0] e_addr; logic [DW-1:0] e_din;
    logic e_st; logic e_vv; logic e_rv;
  } vec_t;

  vec_t          tbl[$];
  logic [DW-1:0] shadow [SCREEN_WORDS];
  logic [DW-1:0] vq[$];
  logic [DW-1:0] cq[$];
  int            total = 0;
  int            bad   = 0;

  // Argument order: reset, vga req/addr, cpu load/read/addr/data,
  // push-vga, push-cpu, new-write, expected we/addr/din/stall/vgaValid/rdValid.
  function automatic vec_t mk(input logic rs, vr, input logic [AW-1:0] va,
                              input logic ld, rd, input logic [AW-1:0] ca,
                              input logic [DW-1:0] cd, input logic pv, pc, wn,
                              input logic e_we, input logic [AW-1:0] e_addr,
                              input logic [DW-1:0] e_din,
                              input logic e_st, e_vv, e_rv);
    vec_t v;
    v.rs = rs; v.vr = vr; v.va = va; v.ld = ld; v.rd = rd; v.ca = ca; v.cd = cd;
    v.pv = pv; v.pc = pc; v.wn = wn; v.e_we = e_we; v.e_addr = e_addr;
    v.e_din = e_din; v.e_st = e_st; v.e_vv = e_vv; v.e_rv = e_rv;
    return v;
  endfunction

  function automatic vec_t idle(input logic e_we, input logic [AW-1:0] e_addr,
                                input logic [DW-1:0] e_din, input logic e_vv);
    return mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, e_we, e_addr, e_din, 0, e_vv, 0);
  endfunction

  function automatic vec_t vga(input logic [AW-1:0] va, input logic e_vv);
    return mk(0, 1, va, 0, 0, 0, 0, 1, 0, 0, 0, va, 0, 0, e_vv, 0);
  endfunction

  task automatic chk(input string nm, input int idx, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s vec=%0d got=%0h want=%0h", nm, idx, act, exp);
    end
  endtask

  task automatic apply(input vec_t v);
    reset   = v.rs;
    vgaReq  = v.vr;
    vgaAddr = v.va;
    cpuLoad = v.ld;
    cpuRead = v.rd;
    cpuAddr = v.ca;
    cpuIn   = v.cd;
    if (v.wn) shadow[v.ca] = v.cd;
    if (v.pv) vq.push_back(shadow[v.va]);
    if (v.pc) cq.push_back(shadow[v.ca]);
  endtask

  task automatic sample(input int i, input vec_t v);
    chk("ramWe", i, 32'(ramWe), 32'(v.e_we));
    chk("ramAddr", i, 32'(ramAddr), 32'(v.e_addr));
    if (v.e_we) chk("ramDin", i, 32'(ramDin), 32'(v.e_din));
    chk("cpuStall", i, 32'(cpuStall), 32'(v.e_st));
    chk("vgaValid", i, 32'(vgaValid), 32'(v.e_vv));
    chk("cpuRdValid", i, 32'(cpuRdValid), 32'(v.e_rv));
    if (v.rs) begin
      chk("rst_ramDin", i, 32'(ramDin), 32'(0));
      chk("rst_vgaData", i, 32'(vgaData), 32'(0));
      chk("rst_cpuOut", i, 32'(cpuOut), 32'(0));
    end
    if (vgaValid === 1'b1) begin
      if (vq.size() == 0) begin
        total++; bad++;
        $display("FAIL vga_unexpected vec=%0d got=%0h want=none", i, vgaData);
      end else chk("vgaData", i, 32'(vgaData), 32'(vq.pop_front()));
    end
    if (cpuRdValid === 1'b1) begin
      if (cq.size() == 0) begin
        total++; bad++;
        $display("FAIL cpu_unexpected vec=%0d got=%0h want=none", i, cpuOut);
      end else chk("cpuOut", i, 32'(cpuOut), 32'(cq.pop_front()));
    end
  endtask

  initial begin
    reset = 1'b1; vgaReq = 0; vgaAddr = '0; cpuLoad = 0; cpuRead = 0;
    cpuAddr = '0; cpuIn = '0;
    for (int k = 0; k < int'(SCREEN_WORDS); k++) shadow[k] = init_val(k);

    // Reset, with active inputs gated off.
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(1, 1, 3, 1, 1, 7, 9, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(idle(0, 0, 0, 0));
    // Single write lands the next cycle.
    tbl.push_back(mk(0, 0, 0, 1, 0, 'h5, 'hBEEF, 0, 0, 1, 0, 0, 0, 0, 0, 0));
    tbl.push_back(idle(1, 'h5, 'hBEEF, 0));
    tbl.push_back(idle(0, 0, 0, 0));
    // Top word VGA fetch.
    tbl.push_back(vga('h1FFF, 0));
    tbl.push_back(idle(0, 0, 0, 1));
    // Back-to-back writes; VGA keeps the first buffered so the second stalls.
    tbl.push_back(mk(0, 0, 0, 1, 0, 'h10, 'h1111, 0, 0, 1, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 1, 'h20, 1, 0, 'h11, 'h2222, 1, 0, 1, 0, 'h20, 0, 1, 0, 0));
    tbl.push_back(mk(0, 0, 0, 1, 0, 'h11, 'h2222, 0, 0, 0, 1, 'h10, 'h1111, 0, 1, 0));
    tbl.push_back(idle(1, 'h11, 'h2222, 0));
    tbl.push_back(idle(0, 0, 0, 0));
    // Plain CPU read.
    tbl.push_back(mk(0, 0, 0, 0, 1, 'h30, 0, 0, 1, 0, 0, 'h30, 0, 1, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 1, 'h30, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1));
    tbl.push_back(idle(0, 0, 0, 0));
    // Read back the written words through VGA.
    tbl.push_back(vga('h10, 0));
    tbl.push_back(vga('h11, 1));
    tbl.push_back(vga('h5, 1));
    tbl.push_back(idle(0, 0, 0, 1));

    // Write pending under 10 VGA requests: 5th is forced to CPU_WR.
    tbl.push_back(mk(0, 0, 0, 1, 0, 'h40, 'hCAFE, 0, 0, 1, 0, 0, 0, 0, 0, 0));
    for (int i = 1; i <= 10; i++) begin
      logic [AW-1:0] a;
      logic          vv;
      a  = AW'(256 + i);
      vv = (i != 1) && (i != 6);
      if (i == 5)
        tbl.push_back(mk(0, 1, a, 0, 0, 0, 0, 0, 0, 0, 1, 'h40, 'hCAFE, 0, vv, 0));
      else
        tbl.push_back(vga(a, vv));
    end
    tbl.push_back(idle(0, 0, 0, 1));

    // Write then read of the same address.
    tbl.push_back(mk(0, 0, 0, 1, 0, 'h50, 'h1234, 0, 0, 1, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 1, 'h50, 0, 0, 1, 0, 1, 'h50, 'h1234, 1, 0, 0));
`ifdef SCREEN_ARB_FWD_EN
    tbl.push_back(mk(0, 0, 0, 0, 1, 'h50, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1));
`else
    tbl.push_back(mk(0, 0, 0, 0, 1, 'h50, 0, 0, 0, 0, 0, 'h50, 0, 1, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 1, 'h50, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1));
`endif
    tbl.push_back(idle(0, 0, 0, 0));

    // Simultaneous load and read, both held while stalled.
    tbl.push_back(mk(0, 0, 0, 1, 1, 'h60, 'h7777, 0, 1, 1, 0, 0, 0, 1, 0, 0));
    tbl.push_back(mk(0, 0, 0, 1, 1, 'h60, 'h7777, 0, 0, 0, 1, 'h60, 'h7777, 1, 0, 0));
`ifdef SCREEN_ARB_FWD_EN
    tbl.push_back(mk(0, 0, 0, 1, 1, 'h60, 'h7777, 0, 0, 0, 0, 0, 0, 1, 0, 1));
`else
    tbl.push_back(mk(0, 0, 0, 1, 1, 'h60, 'h7777, 0, 0, 0, 0, 'h60, 0, 1, 0, 0));
    tbl.push_back(mk(0, 0, 0, 1, 1, 'h60, 'h7777, 0, 0, 0, 0, 0, 0, 1, 0, 1));
`endif
    tbl.push_back(idle(0, 0, 0, 0));

    // Reset with a buffered write and a VGA read in flight.
    tbl.push_back(mk(0, 1, 'h80, 1, 0, 'h70, 'hDEAD, 1, 0, 0, 0, 'h80, 0, 0, 0, 0));
    tbl.push_back(mk(0, 1, 'h81, 0, 0, 0, 0, 0, 0, 0, 0, 'h81, 0, 0, 1, 0));
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(idle(0, 0, 0, 0));
    tbl.push_back(idle(0, 0, 0, 0));
    tbl.push_back(idle(0, 0, 0, 0));
    tbl.push_back(vga('h70, 0));
    tbl.push_back(idle(0, 0, 0, 1));

    for (int i = 0; i < tbl.size(); i++) begin
      @(posedge clk);
      #1;
      apply(tbl[i]);
      @(negedge clk);
      sample(i, tbl[i]);
    end

    chk("vga_queue_left", tbl.size(), 32'(vq.size()), 32'(0));
    chk("cpu_queue_left", tbl.size(), 32'(cq.size()), 32'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
